rv_fetch_queue: RTL and testbench

Instruction fetch front end that sits directly upstream of the core's IF/ID pipeline register. It issues sequential word fetches to an instruction memory over a request/grant bus with in-order, variable-latency responses. It buffers up to DEPTH fetched instructions with their PCs in a small queue and hands them to the core over a valid/ready interface. A redirect from the core (taken branch, jal/jalr, mispredict flush) restarts fetch at a new PC and discards every stale in-flight response.

---
 rtl/rv_fetch_queue_pkg.sv | 14 +
 rtl/rv_fetch_fifo.sv | 62 ++++++
 rtl/rv_fetch_queue.sv | 102 ++++++++++
 tb/tb_rv_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_queue_pkg.sv
// Shared widths and constants for the instruction fetch queue.
package rv_fetch_queue_pkg;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned ILEN             = 32;

  // Queue entry is {pc, instr}: instr in the low ILEN bits, pc above it.
  function automatic int unsigned entry_width(input int unsigned xlen);
    return xlen + ILEN;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO with flush; count = wr - rd on extended pointers.
module rv_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      // A push into a full queue lands in the slot the simultaneous pop frees.
      if (push_i) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
        wr_ptr_d                = wr_ptr_q + CW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && (count_o == CW'(DEPTH))))
    else $error("rv_fetch_fifo: push while full without pop");

endmodule

// File: rtl/rv_fetch_queue.sv
// Sequential instruction fetch with credit-limited issue, redirect and
// stale-response discard, feeding a small {pc, instr} queue.
module rv_fetch_queue
  import rv_fetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;
  localparam int unsigned EW = entry_width(XLEN);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [SW-1:0]   used;
  logic [XLEN-1:0] redirect_pc;
  logic            gnt_fire;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  assign redirect_pc   = redirect_pc_i & ~XLEN'(3);
  assign used          = SW'(count) + SW'(inflight_q);
  // Credit: never have more outstanding than free queue slots.
  assign imem_req_o    = !rst && !redirect_i && (used < SW'(DEPTH));
  assign imem_addr_o   = fetch_pc_q;
  assign gnt_fire      = imem_req_o && imem_gnt_i;
  assign push          = imem_rvalid_i && !redirect_i && (discard_q == '0);
  assign instr_valid_o = (count != '0) && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = head[ILEN-1:0];
  assign pc_o          = head[EW-1:ILEN];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = inflight_q - CW'(imem_rvalid_i);
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)     resp_pc_d  = resp_pc_q + XLEN'(4);
      if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i ({resp_pc_q, imem_rdata_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  rvalid_chk: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (inflight_q != '0))
    else $error("rv_fetch_queue: rvalid with nothing in flight");

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: memory model with fixed latency and an
// expected-PC stream model checking every delivered instruction.
module tb_rv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        req;
  logic [63:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [63:0] pc;

  always #5 clk = ~clk;

  rv_fetch_queue #(.DEPTH(4), .XLEN(64), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .pc_o          (pc)
  );

  typedef struct { logic [63:0] addr; int due; } resp_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; int cyc; } got_t;

  resp_t resp_q[$];
  got_t  got_q[$];
  int    cyc, lat, n_grants, n_checks, n_fail;
  logic        obs_req, obs_valid;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One bus cycle; called at a negedge with inputs already driven.
  task automatic cycle();
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(resp_q[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    #1;
    obs_req = req; obs_addr = addr; obs_valid = valid; obs_pc = pc; obs_instr = instr;
    if (rvalid) void'(resp_q.pop_front());
    if (req && gnt) begin
      resp_q.push_back('{addr: addr, due: cyc + lat});
      n_grants++;
    end
    if (valid && ready) got_q.push_back('{pc: pc, instr: instr, cyc: cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; rvalid = 1'b0; redirect = 1'b0; gnt = 1'b0; ready = 1'b0;
    resp_q.delete(); got_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; cyc = 0; n_grants = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0; ready = 1'b0;
    rvalid = 1'b0; rdata = '0; lat = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (req !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %b exp 0", req); end
    n_checks++; if (addr !== 64'h0)  begin n_fail++; $display("FAIL reset_addr: got %h exp 0", addr); end
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", instr); end
    n_checks++; if (pc !== 64'h0)    begin n_fail++; $display("FAIL reset_pc: got %h exp 0", pc); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    gnt = 1'b1; ready = 1'b1; lat = 1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_checks++;
      if (obs_req !== 1'b1 || obs_addr !== 64'(4 * k)) begin
        n_fail++; $display("FAIL stream_req c%0d: got req=%b addr=%h exp req=1 addr=%h", k, obs_req, obs_addr, 64'(4 * k));
      end
      n_checks++;
      if (obs_valid !== (k >= 2)) begin
        n_fail++; $display("FAIL stream_valid c%0d: got %b exp %b", k, obs_valid, (k >= 2));
      end
      if (k >= 2) begin
        n_checks++;
        if (obs_pc !== 64'(4 * (k - 2)) || obs_instr !== mem_word(64'(4 * (k - 2)))) begin
          n_fail++; $display("FAIL stream_head c%0d: got pc=%h instr=%h exp pc=%h instr=%h",
                             k, obs_pc, obs_instr, 64'(4 * (k - 2)), mem_word(64'(4 * (k - 2))));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc;
    int          n_del;
    do_reset();
    gnt = 1'b1; ready = 1'b0; lat = 1;
    repeat (10) cycle();
    n_checks++; if (n_grants != 4)      begin n_fail++; $display("FAIL bp_grants: got %0d exp 4", n_grants); end
    n_checks++; if (obs_req !== 1'b0)   begin n_fail++; $display("FAIL bp_req: got %b exp 0", obs_req); end
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 64'h0) begin
      n_fail++; $display("FAIL bp_head: got valid=%b pc=%h exp valid=1 pc=0", obs_valid, obs_pc);
    end
    n_checks++; if (got_q.size() != 0)  begin n_fail++; $display("FAIL bp_no_pop: got %0d pops exp 0", got_q.size()); end
    ready = 1'b1; exp_pc = 64'h0; n_del = 0;
    repeat (12) cycle();
    while (got_q.size() > 0) begin
      got_t g;
      g = got_q.pop_front();
      n_checks++;
      if (g.pc !== exp_pc || g.instr !== mem_word(exp_pc)) begin
        n_fail++; $display("FAIL bp_drain: got pc=%h instr=%h exp pc=%h instr=%h", g.pc, g.instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 64'd4; n_del++;
    end
    n_checks++; if (n_del < 10) begin n_fail++; $display("FAIL bp_rate: got %0d delivered exp >=10", n_del); end
  endtask

  task automatic test_mixed();
    logic [63:0] exp_pc;
    int          n_del;
    do_reset();
    lat = 3; exp_pc = 64'h0; n_del = 0;
    for (int i = 0; i < 400; i++) begin
      gnt         = ($urandom_range(0, 2) != 0);
      ready       = ($urandom_range(0, 1) != 0);
      redirect    = ($urandom_range(0, 29) == 0) || (redirect && $urandom_range(0, 1) == 0);
      redirect_pc = {$urandom, $urandom};
      cycle();
      while (got_q.size() > 0) begin
        got_t g;
        g = got_q.pop_front();
        n_checks++;
        if (g.pc !== exp_pc || g.instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL mixed_seq: got pc=%h instr=%h exp pc=%h instr=%h", g.pc, g.instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 64'd4; n_del++;
      end
      if (redirect) exp_pc = redirect_pc & ~64'h3;
    end
    redirect = 1'b0;
    n_checks++; if (n_del < 40) begin n_fail++; $display("FAIL mixed_progress: got %0d delivered exp >=40", n_del); end
  endtask

  task automatic test_redirect();
    logic [63:0] exp_pc;
    int          guard, r;
    do_reset();
    gnt = 1'b1; ready = 1'b1; lat = 3; exp_pc = 64'h0; guard = 0;
    while (resp_q.size() != 3 && guard < 50) begin cycle(); guard++; end
    n_checks++; if (resp_q.size() != 3) begin n_fail++; $display("FAIL redir_setup: got %0d in flight exp 3", resp_q.size()); end
    while (got_q.size() > 0) begin
      got_t g;
      g = got_q.pop_front();
      n_checks++;
      if (g.pc !== exp_pc) begin n_fail++; $display("FAIL redir_pre: got pc=%h exp %h", g.pc, exp_pc); end
      exp_pc += 64'd4;
    end
    r = cyc; redirect = 1'b1; redirect_pc = 64'h1000;
    cycle();
    n_checks++; if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle: got valid=%b req=%b exp 0 0", obs_valid, obs_req);
    end
    redirect = 1'b0;
    cycle();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h1000) begin
      n_fail++; $display("FAIL redir_addr: got req=%b addr=%h exp req=1 addr=1000", obs_req, obs_addr);
    end
    guard = 0;
    while (got_q.size() == 0 && guard < 30) begin cycle(); guard++; end
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL redir_first: got no delivery exp pc=1000");
    end else if (got_q[0].pc !== 64'h1000 || got_q[0].cyc != r + 5 || got_q[0].instr !== mem_word(64'h1000)) begin
      n_fail++; $display("FAIL redir_first: got pc=%h cyc=%0d exp pc=1000 cyc=%0d", got_q[0].pc, got_q[0].cyc, r + 5);
    end
  endtask

  task automatic test_redirect_full();
    int guard;
    do_reset();
    gnt = 1'b1; ready = 1'b0; lat = 3; guard = 0;
    while (!(resp_q.size() == 1 && resp_q[0].due <= cyc) && guard < 40) begin cycle(); guard++; end
    n_checks++; if (guard >= 40) begin n_fail++; $display("FAIL redirfull_setup: got timeout exp rvalid with 1 in flight"); end
    redirect = 1'b1; redirect_pc = 64'h2003;
    cycle();
    n_checks++; if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL redirfull_cycle: got valid=%b req=%b exp 0 0", obs_valid, obs_req);
    end
    redirect = 1'b0;
    cycle();
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL redirfull_empty: got valid=%b exp 0", obs_valid); end
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h2000) begin
      n_fail++; $display("FAIL redirfull_addr: got req=%b addr=%h exp req=1 addr=2000", obs_req, obs_addr);
    end
    ready = 1'b1; guard = 0;
    while (got_q.size() == 0 && guard < 30) begin cycle(); guard++; end
    n_checks++;
    if (got_q.size() == 0 || got_q[0].pc !== 64'h2000 || got_q[0].instr !== mem_word(64'h2000)) begin
      n_fail++; $display("FAIL redirfull_first: got %0d items pc=%h exp pc=2000", got_q.size(),
                         (got_q.size() > 0) ? got_q[0].pc : 64'hx);
    end
  endtask

  task automatic test_reset_midstream();
    int guard;
    do_reset();
    gnt = 1'b1; ready = 1'b1; lat = 3; guard = 0;
    while (resp_q.size() != 2 && guard < 20) begin cycle(); guard++; end
    n_checks++; if (resp_q.size() != 2) begin n_fail++; $display("FAIL rstmid_setup: got %0d in flight exp 2", resp_q.size()); end
    rst = 1'b1;
    #1;
    n_checks++; if (req !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got req=%b valid=%b exp 0 0", req, valid);
    end
    n_checks++; if (addr !== 64'h0 || pc !== 64'h0 || instr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_data: got addr=%h pc=%h instr=%h exp 0 0 0", addr, pc, instr);
    end
    resp_q.delete(); got_q.delete(); rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; cyc = 0; n_grants = 0;
    cycle();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_restart: got req=%b addr=%h exp req=1 addr=0", obs_req, obs_addr);
    end
    guard = 0;
    while (got_q.size() == 0 && guard < 20) begin cycle(); guard++; end
    n_checks++;
    if (got_q.size() == 0 || got_q[0].pc !== 64'h0 || got_q[0].cyc != 4 || got_q[0].instr !== mem_word(64'h0)) begin
      n_fail++; $display("FAIL rstmid_first: got %0d items pc=%h cyc=%0d exp pc=0 cyc=4", got_q.size(),
                         (got_q.size() > 0) ? got_q[0].pc : 64'hx, (got_q.size() > 0) ? got_q[0].cyc : -1);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; n_grants = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_mixed();
    test_redirect();
    test_redirect_full();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion exp finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
